// File: rtl/rs_int_issue.sv
// Integer reservation-station issue selector: round-robin pick of a READY line,
// one-hot issue pulse, and a one-entry valid/ready output register toward the ALU.
`ifndef RS_STATE_BUS
`define RS_STATE_BUS    3
`define RS_STATE_NONE   3'd0
`define RS_STATE_WAIT   3'd1
`define RS_STATE_READY  3'd2
`define RS_STATE_WRITE  3'd3
`define RS_STATE_COMMIT 3'd4
`endif
`ifndef ROB_ADDR_BUS
`define ROB_ADDR_BUS    5
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS    4
`endif
`ifndef OPGEN_BUS
`define OPGEN_BUS       8
`endif
`ifndef DATA_BUS
`define DATA_BUS        32
`endif

module rs_int_issue #(
    parameter int LINE_NUM  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [LINE_NUM*`RS_STATE_BUS-1:0]     rs_state_in,
    input  logic [LINE_NUM*`ROB_ADDR_BUS-1:0]     rob_addr_in,
    input  logic [LINE_NUM*`EXC_TYPE_BUS-1:0]     exc_type_in,
    input  logic [LINE_NUM*`OPGEN_BUS-1:0]        opgen_in,
    input  logic [LINE_NUM*`DATA_BUS-1:0]         operand_1_in,
    input  logic [LINE_NUM*`DATA_BUS-1:0]         operand_2_in,
    output logic [LINE_NUM-1:0]                   issue_en,
    output logic                                  alu_valid,
    input  logic                                  alu_ready,
    output logic [IDX_WIDTH-1:0]                  alu_line_idx,
    output logic [`ROB_ADDR_BUS-1:0]              alu_rob_addr,
    output logic [`EXC_TYPE_BUS-1:0]              alu_exc_type,
    output logic [`OPGEN_BUS-1:0]                 alu_opgen,
    output logic [`DATA_BUS-1:0]                  alu_operand_1,
    output logic [`DATA_BUS-1:0]                  alu_operand_2
);

    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] sel;
    logic                 any_ready;
    logic                 can_take;
    logic                 fire;

    // Scan starts at rr_ptr; index arithmetic wraps since LINE_NUM is a power of two.
    always_comb begin
        logic [IDX_WIDTH-1:0] idx;
        sel       = '0;
        any_ready = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < LINE_NUM; k++) begin
            idx = rr_ptr + IDX_WIDTH'(k);
            if (!any_ready &&
                rs_state_in[idx*`RS_STATE_BUS +: `RS_STATE_BUS] == `RS_STATE_READY) begin
                any_ready = 1'b1;
                sel       = idx;
            end
        end
    end

    assign can_take = !alu_valid || alu_ready;
    assign fire     = can_take && any_ready && !flush && !rst;

    always_comb begin
        issue_en = '0;
        if (fire) issue_en[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            alu_valid     <= 1'b0;
            alu_line_idx  <= '0;
            alu_rob_addr  <= '0;
            alu_exc_type  <= '0;
            alu_opgen     <= '0;
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
        end else if (flush) begin
            alu_valid <= 1'b0;
        end else if (fire) begin
            rr_ptr        <= sel + IDX_WIDTH'(1);
            alu_valid     <= 1'b1;
            alu_line_idx  <= sel;
            alu_rob_addr  <= rob_addr_in[sel*`ROB_ADDR_BUS +: `ROB_ADDR_BUS];
            alu_exc_type  <= exc_type_in[sel*`EXC_TYPE_BUS +: `EXC_TYPE_BUS];
            alu_opgen     <= opgen_in[sel*`OPGEN_BUS +: `OPGEN_BUS];
            alu_operand_1 <= operand_1_in[sel*`DATA_BUS +: `DATA_BUS];
            alu_operand_2 <= operand_2_in[sel*`DATA_BUS +: `DATA_BUS];
        end else if (alu_ready) begin
            alu_valid <= 1'b0;
        end
    end

endmodule
